// File: rtl/cpu_clock_ctrl.sv
// Run/stop and single-step clock generator for a hand-clocked CPU.
// Produces a divided main_clk from the board clock with debounced front-panel controls.
module cpu_clock_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned STEP_PERIODS    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  div_sel,
    input  logic        halt,
    output logic        main_clk,
    output logic        busy,
    output logic [15:0] cycle_cnt
);

    localparam int unsigned HP_W  = 22;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SP_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {IDLE, RUN, STEP, DRAIN} state_e;

    logic [1:0]       sync1_q, sync2_q;
    logic             run_deb_q, step_deb_q, step_prev_q;
    logic [DB_W-1:0]  run_dbc_q, step_dbc_q;
    logic             step_req_c;

    state_e           state_q, state_d;
    logic             mclk_q, mclk_d;
    logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [SP_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             rise_c, fall_c, term_c, stop_c;

    function automatic logic [HP_W-1:0] hp_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return HP_W'(1);
            2'd1:    return HP_W'(4);
            2'd2:    return HP_W'(25000);
            default: return HP_W'(2500000);
        endcase
    endfunction

    // Bit 0 carries run_sw, bit 1 carries step_btn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            step_prev_q <= 1'b0;
        end else begin
            sync1_q     <= {step_btn, run_sw};
            sync2_q     <= sync1_q;
            step_prev_q <= step_deb_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_dbc_q <= '0;
            run_deb_q <= 1'b0;
        end else if (sync2_q[0] == run_deb_q) begin
            run_dbc_q <= '0;
        end else if (run_dbc_q == DB_LAST) begin
            run_dbc_q <= '0;
            run_deb_q <= sync2_q[0];
        end else begin
            run_dbc_q <= run_dbc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step_dbc_q <= '0;
            step_deb_q <= 1'b0;
        end else if (sync2_q[1] == step_deb_q) begin
            step_dbc_q <= '0;
        end else if (step_dbc_q == DB_LAST) begin
            step_dbc_q <= '0;
            step_deb_q <= sync2_q[1];
        end else begin
            step_dbc_q <= step_dbc_q + 1'b1;
        end
    end

    assign step_req_c = step_deb_q & ~step_prev_q;

    // Next-state logic; rise/fall requests are applied uniformly after the case.
    always_comb begin
        state_d  = state_q;
        mclk_d   = mclk_q;
        hp_cnt_d = hp_cnt_q;
        hp_d     = hp_q;
        per_d    = per_q;
        cyc_d    = cyc_q;
        rise_c   = 1'b0;
        fall_c   = 1'b0;
        term_c   = (hp_cnt_q == '0);
        stop_c   = ~run_deb_q | halt;

        case (state_q)
            IDLE: begin
                mclk_d   = 1'b0;
                hp_cnt_d = '0;
                per_d    = '0;
                if (!halt && run_deb_q) begin
                    state_d = RUN;
                    rise_c  = 1'b1;
                end else if (!halt && step_req_c) begin
                    state_d = STEP;
                    rise_c  = 1'b1;
                    per_d   = SP_LAST;
                end
            end
            RUN: begin
                if (stop_c) state_d = DRAIN;
                if (!term_c)     hp_cnt_d = hp_cnt_q - HP_W'(1);
                else if (mclk_q) fall_c = 1'b1;
                else if (!stop_c) rise_c = 1'b1;
            end
            STEP: begin
                if (!term_c) begin
                    hp_cnt_d = hp_cnt_q - HP_W'(1);
                end else if (mclk_q) begin
                    fall_c = 1'b1;
                end else if (per_q == '0) begin
                    state_d = IDLE;
                end else begin
                    per_d  = per_q - SP_W'(1);
                    rise_c = 1'b1;
                end
            end
            DRAIN: begin
                // A high half in flight runs to full length; never cut short.
                if (!mclk_q) begin
                    state_d = IDLE;
                end else if (term_c) begin
                    fall_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hp_cnt_d = hp_cnt_q - HP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // div_sel is only captured at the start of each high half.
        if (rise_c) begin
            mclk_d   = 1'b1;
            hp_d     = hp_of(div_sel);
            hp_cnt_d = hp_of(div_sel) - HP_W'(1);
            cyc_d    = cyc_q + CNT_W'(1);
        end
        if (fall_c) begin
            mclk_d   = 1'b0;
            hp_cnt_d = hp_q - HP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mclk_q   <= 1'b0;
            hp_cnt_q <= '0;
            hp_q     <= '0;
            per_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mclk_q   <= mclk_d;
            hp_cnt_q <= hp_cnt_d;
            hp_q     <= hp_d;
            per_q    <= per_d;
            cyc_q    <= cyc_d;
        end
    end

    assign main_clk  = mclk_q;
    assign busy      = (state_q != IDLE);
    assign cycle_cnt = cyc_q;

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable clk cycles before a debounced input changes.
REQ-002 Parameter STEP_PERIODS, default 2, is the number of main_clk periods emitted per step request; 2 gives one divided CPU clock period.
REQ-003 clk  input  1  board clock; all state is clocked on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 run_sw  input  1  raw run/stop switch; 1 = free-run requested.
REQ-006 step_btn  input  1  raw single-step pushbutton, active-high.
REQ-007 div_sel  input  2  half-period select: 0→1, 1→4, 2→25000, 3→2500000 clk cycles.
REQ-008 halt  input  1  CPU halt request; synchronous to clk.
REQ-009 main_clk  output  1  registered generated clock for the downstream clock/mem-clock divider.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 cycle_cnt  output  16  count of main_clk rising edges.

Function
REQ-012 run_sw and step_btn SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Each synchronized input SHALL have its own debouncer: the debounced value takes the synchronized value only after the two have differed for DEBOUNCE_CYCLES consecutive clk cycles; any return to agreement clears the counter.
REQ-014 A rising edge of debounced step SHALL produce a one-clk step_req pulse.
REQ-015 The half-period counter SHALL reload from the div_sel mapping; main_clk toggles on the cycle the counter reaches terminal count.
REQ-016 div_sel SHALL be sampled only at the start of each high half (when main_clk rises); a mid-period change takes effect from the next period.
REQ-017 FSM states SHALL be IDLE, RUN, STEP, DRAIN.
REQ-018 IDLE: main_clk held 0, counters cleared. Enter RUN when debounced run = 1 and halt = 0. Otherwise enter STEP on step_req when halt = 0. RUN has priority over STEP.
REQ-019 RUN: main_clk toggles continuously. Enter DRAIN when debounced run = 0 or halt = 1.
REQ-020 DRAIN: the current high half, if any, completes at full length. Return to IDLE on the cycle main_clk is, or becomes, 0, so no runt pulse is ever emitted.
REQ-021 STEP: emit exactly STEP_PERIODS full main_clk periods (each HP high then HP low), then return to IDLE.
REQ-022 In STEP, halt and run changes SHALL be ignored until the step sequence completes.
REQ-023 step_req pulses arriving while busy = 1 SHALL be discarded, not queued.
REQ-024 The first main_clk rising edge after leaving IDLE SHALL occur one clk cycle after the transition.
REQ-025 cycle_cnt SHALL increment on every main_clk 0→1 transition and wrap from 16'hFFFF to 0 with no flag.
REQ-026 busy SHALL be combinationally derived from the state register (state != IDLE).

Reset
REQ-027 While resetn = 0, the block SHALL hold the following values:
- main_clk = 0, busy = 0, cycle_cnt = 0.
- FSM in IDLE.
- Synchronizers, debounced values and all counters cleared to 0.
REQ-028 Deassertion of reset SHALL begin operation on the next clk rising edge. Assertion mid-period SHALL force main_clk low immediately, with no completion of the period.

Verification
REQ-029 DEBOUNCE_CYCLES=4, div_sel=0, run_sw=1 held. Required: after sync + debounce, main_clk toggles every clk cycle (period 2 clk) and cycle_cnt increments by 1 per period.
REQ-030 Idle, div_sel=1, one clean step_btn press. Required, in this order:
- main_clk shows exactly 2 periods of 4 clk high / 4 clk low.
- busy goes high for 16 clk cycles.
- cycle_cnt ends at 2.
REQ-031 step_btn bouncing at 1-cycle intervals for 3 cycles with DEBOUNCE_CYCLES=4 -> no step_req and main_clk stays 0. A second press during busy -> no extra periods.
REQ-032 div_sel=1, RUN, halt asserted 1 clk after a main_clk rise. Required:
- the high half completes its full 4 cycles;
- main_clk falls and the FSM enters IDLE;
- busy falls with no further rise.
REQ-033 resetn pulsed low while main_clk = 1 in RUN -> main_clk = 0 and cycle_cnt = 0 in the same cycle. After release with run_sw=1, run resumes after the debounce delay.
REQ-034 cycle_cnt preloaded by running 65535 periods, then one more rise -> cycle_cnt = 0.
